// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: shared mode, state and rule encodings for the LED pattern engine
package led_pattern_pkg;
    localparam logic [1:0] MODE_OFF      = 2'b00;
    localparam logic [1:0] MODE_BOUNCE   = 2'b01;
    localparam logic [1:0] MODE_CONVERGE = 2'b10;
    localparam logic [1:0] MODE_AUTO     = 2'b11;
    localparam logic RULE_BOUNCE   = 1'b0;
    localparam logic RULE_CONVERGE = 1'b1;
    typedef enum logic [2:0] {
        ST_OFF,
        ST_BOUNCE,
        ST_CONVERGE,
        ST_AUTO_BOUNCE,
        ST_AUTO_CONVERGE
    } state_t;
    function automatic state_t start_state(input logic [1:0] m);
        return m == MODE_BOUNCE ? ST_BOUNCE :
               m == MODE_CONVERGE ? ST_CONVERGE :
               m == MODE_AUTO ? ST_AUTO_BOUNCE : ST_OFF;
    endfunction
endpackage

// File: rtl/step_prescaler.sv
// step_prescaler: divides clk into one-cycle step strobes every tick_div+1 enabled cycles
module step_prescaler #(
    parameter int PRESCALE_W = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] tick_div,
    output logic                  step
);
    logic [PRESCALE_W-1:0] count;
    assign step = en && !clr && count == tick_div;
    // count up while enabled; a lowered tick_div below the count snaps it back to 0
    always_ff @(posedge clk) begin
        if (rst || clr) count <= '0;
        else if (en) count <= count >= tick_div ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/led_pattern_engine.sv
// led_pattern_engine: bounce/converge LED pattern FSM with automatic rule alternation
module led_pattern_engine
    import led_pattern_pkg::*;
#(
    parameter int N_LEDS     = 27,
    parameter int BLOCK_W    = 3,
    parameter int PRESCALE_W = 24,
    parameter int REPEATS    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] tick_div,
    output logic [N_LEDS-1:0]     leds,
    output logic                  dir,
    output logic                  rule_active,
    output logic                  cycle_done
);
    localparam int PW = $clog2(N_LEDS + 1);
    localparam int RW = $clog2(REPEATS + 1);
    localparam int MAXPOS = N_LEDS - BLOCK_W;
    localparam int HALF = (N_LEDS + 1) / 2;
    localparam logic [N_LEDS-1:0] BLK = {N_LEDS{1'b1}} >> (N_LEDS - BLOCK_W);

    state_t          state;
    logic [1:0]      mode_q;
    logic [PW-1:0]   pos, np, top;
    logic [RW-1:0]   rep;
    logic            reinit, step, is_conv, is_auto, done, nd, swap;

    // pos doubles as the converge level k; the rule picks how it is drawn
    function automatic logic [N_LEDS-1:0] render(input logic conv, input logic [PW-1:0] k);
        logic [N_LEDS-1:0] m;
        for (int i = 0; i < N_LEDS; i++) m[i] = i < int'(k) || i >= N_LEDS - int'(k);
        return conv ? m : BLK << k;
    endfunction

    assign reinit = mode != mode_q;

    step_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (reinit || mode_q == MODE_OFF),
        .tick_div (tick_div),
        .step     (step)
    );

    // next position/direction for a step and whether it closes a cycle or swaps rules
    always_comb begin
        is_conv = state == ST_CONVERGE || state == ST_AUTO_CONVERGE;
        is_auto = state == ST_AUTO_BOUNCE || state == ST_AUTO_CONVERGE;
        top = is_conv ? PW'(HALF) : PW'(MAXPOS);
        np = dir ? pos - 1'b1 : pos + 1'b1;
        done = dir && np == '0;
        nd = dir ? np != '0 : np == top;
        swap = is_auto && done && rep == RW'(REPEATS - 1);
    end

    // control FSM: reset, mode-change reinit (beats any step), then stepping
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_OFF;
            mode_q <= MODE_OFF;
            pos <= '0;
            dir <= 1'b0;
            rep <= '0;
            leds <= '0;
            rule_active <= RULE_BOUNCE;
            cycle_done <= 1'b0;
        end else if (reinit) begin
            state <= start_state(mode);
            mode_q <= mode;
            pos <= '0;
            dir <= 1'b0;
            rep <= '0;
            leds <= mode == MODE_OFF ? '0 : render(mode == MODE_CONVERGE, '0);
            rule_active <= mode == MODE_CONVERGE ? RULE_CONVERGE : RULE_BOUNCE;
            cycle_done <= 1'b0;
        end else begin
            cycle_done <= step && state != ST_OFF && done;
            if (step && state != ST_OFF) begin
                state <= swap ? (is_conv ? ST_AUTO_BOUNCE : ST_AUTO_CONVERGE) : state;
                pos <= swap ? '0 : np;
                dir <= swap ? 1'b0 : nd;
                rep <= swap ? '0 : (is_auto && done) ? rep + 1'b1 : rep;
                leds <= swap ? render(!is_conv, '0) : render(is_conv, np);
                rule_active <= swap ? !is_conv : is_conv;
            end
        end
    end
endmodule

// File: tb/tb_led_pattern_engine.sv
// tb_led_pattern_engine: randomized checks of the LED pattern engine against a phase-based model
module tb_led_pattern_engine;
    localparam int N = 27;
    localparam int BW = 3;
    localparam int PSW = 24;
    localparam int REP = 2;
    localparam int MAXPOS = N - BW;
    localparam int HALF = (N + 1) / 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b1;
    logic [1:0]     mode = 2'b00;
    logic [PSW-1:0] tick_div = '0;
    logic [N-1:0]   leds;
    logic           dir, rule_active, cycle_done;

    int n_tests = 0;
    int n_fail = 0;

    int mq, cnt, phase, rule, rep;
    logic [N-1:0] e_leds;
    logic e_dir, e_done, e_rule;

    led_pattern_engine #(.N_LEDS(N), .BLOCK_W(BW), .PRESCALE_W(PSW), .REPEATS(REP)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .tick_div    (tick_div),
        .leds        (leds),
        .dir         (dir),
        .rule_active (rule_active),
        .cycle_done  (cycle_done)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] pat(input int r, input int lvl);
        logic [N-1:0] m;
        logic [N-1:0] blk;
        blk = '0;
        for (int i = 0; i < BW; i++) blk[i] = 1'b1;
        for (int i = 0; i < N; i++) m[i] = (i < lvl) || (i >= N - lvl);
        return r != 0 ? m : blk << lvl;
    endfunction

    // each rule is a phase counter around a triangle 0..top..0; level and dir come from the phase
    task automatic model();
        int top, lvl, period;
        bit stepped;
        e_done = 1'b0;
        if (rst) begin
            mq = 0; cnt = 0; phase = 0; rule = 0; rep = 0;
        end else if (int'(mode) != mq) begin
            mq = int'(mode); cnt = 0; phase = 0; rep = 0; rule = (mode == 2'b10) ? 1 : 0;
        end else begin
            stepped = en && mq != 0 && cnt == int'(tick_div);
            if (en && mq != 0) cnt = (cnt >= int'(tick_div)) ? 0 : cnt + 1;
            if (stepped) begin
                period = rule != 0 ? 2 * HALF : 2 * MAXPOS;
                phase = (phase + 1) % period;
                if (phase == 0) begin
                    e_done = 1'b1;
                    if (mq == 3) begin
                        rep++;
                        if (rep == REP) begin
                            rep = 0;
                            rule = 1 - rule;
                        end
                    end
                end
            end
        end
        if (mq == 0) begin
            e_leds = '0; e_dir = 1'b0; e_rule = 1'b0;
        end else begin
            top = rule != 0 ? HALF : MAXPOS;
            lvl = phase <= top ? phase : 2 * top - phase;
            e_dir = phase >= top;
            e_rule = rule != 0;
            e_leds = pat(rule, lvl);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 2'b00; en = 1'b1; tick_div = '0;
        tick(); tick();
        n_tests++;
        if (leds !== '0) begin n_fail++; $display("FAIL reset_leds got %h exp 0", leds); end
        n_tests++;
        if (dir !== 1'b0) begin n_fail++; $display("FAIL reset_dir got %b exp 0", dir); end
        n_tests++;
        if (rule_active !== 1'b0) begin n_fail++; $display("FAIL reset_rule got %b exp 0", rule_active); end
        n_tests++;
        if (cycle_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", cycle_done); end
    endtask

    task automatic test_bounce();
        int last = -1;
        logic pdir = 1'b0;
        rst = 1'b1; mode = 2'b01; tick_div = '0; en = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_tests++;
        if (leds !== 27'h7) begin n_fail++; $display("FAIL bounce_first got %h exp 7", leds); end
        for (int i = 0; i < 150; i++) begin
            tick();
            n_tests++;
            if ({leds, dir, rule_active, cycle_done} !== {e_leds, e_dir, e_rule, e_done}) begin
                n_fail++;
                $display("FAIL bounce_model got %h/%b/%b/%b exp %h/%b/%b/%b", leds, dir, rule_active, cycle_done, e_leds, e_dir, e_rule, e_done);
            end
            if (dir && !pdir) begin
                n_tests++;
                if (leds !== 27'h7000000) begin n_fail++; $display("FAIL bounce_dir_rise got %h exp 7000000", leds); end
            end
            pdir = dir;
            if (cycle_done) begin
                if (last >= 0) begin
                    n_tests++;
                    if (i - last != 48) begin n_fail++; $display("FAIL bounce_period got %0d exp 48", i - last); end
                end
                last = i;
            end
        end
    endtask

    task automatic test_converge();
        int last = -1;
        mode = 2'b10;
        tick();
        n_tests++;
        if (leds !== '0) begin n_fail++; $display("FAIL conv_start got %h exp 0", leds); end
        tick();
        n_tests++;
        if (leds !== 27'h4000001) begin n_fail++; $display("FAIL conv_k1 got %h exp 4000001", leds); end
        for (int i = 0; i < 13; i++) tick();
        n_tests++;
        if (leds !== 27'h7FFFFFF) begin n_fail++; $display("FAIL conv_k14 got %h exp 7ffffff", leds); end
        for (int i = 0; i < 80; i++) begin
            tick();
            n_tests++;
            if ({leds, dir, rule_active, cycle_done} !== {e_leds, e_dir, e_rule, e_done}) begin
                n_fail++;
                $display("FAIL conv_model got %h/%b/%b/%b exp %h/%b/%b/%b", leds, dir, rule_active, cycle_done, e_leds, e_dir, e_rule, e_done);
            end
            if (cycle_done) begin
                if (last >= 0) begin
                    n_tests++;
                    if (i - last != 28) begin n_fail++; $display("FAIL conv_period got %0d exp 28", i - last); end
                end
                last = i;
            end
        end
    endtask

    task automatic test_auto();
        int rise = -1;
        int fall = -1;
        logic pr = 1'b0;
        mode = 2'b11; tick_div = 24'd1;
        tick();
        for (int i = 1; i <= 800; i++) begin
            tick();
            n_tests++;
            if ({leds, dir, rule_active, cycle_done} !== {e_leds, e_dir, e_rule, e_done}) begin
                n_fail++;
                $display("FAIL auto_model got %h/%b/%b/%b exp %h/%b/%b/%b", leds, dir, rule_active, cycle_done, e_leds, e_dir, e_rule, e_done);
            end
            if (rule_active && !pr && rise < 0) begin
                rise = i;
                n_tests++;
                if (leds !== '0) begin n_fail++; $display("FAIL auto_swap_leds got %h exp 0", leds); end
            end
            if (!rule_active && pr && fall < 0) fall = i;
            pr = rule_active;
        end
        n_tests++;
        if (rise != 192) begin n_fail++; $display("FAIL auto_rise got %0d exp 192", rise); end
        n_tests++;
        if (fall != 304) begin n_fail++; $display("FAIL auto_fall got %0d exp 304", fall); end
    endtask

    task automatic test_prescale_en();
        logic [N-1:0] hl;
        logic hd;
        mode = 2'b01; tick_div = 24'd4; en = 1'b1;
        for (int i = 0; i < 43; i++) begin
            tick();
            n_tests++;
            if ({leds, dir, rule_active, cycle_done} !== {e_leds, e_dir, e_rule, e_done}) begin
                n_fail++;
                $display("FAIL presc_model got %h/%b/%b/%b exp %h/%b/%b/%b", leds, dir, rule_active, cycle_done, e_leds, e_dir, e_rule, e_done);
            end
        end
        hl = leds; hd = dir; en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_tests++;
            if ({leds, dir, cycle_done} !== {hl, hd, 1'b0}) begin
                n_fail++;
                $display("FAIL en_hold got %h/%b/%b exp %h/%b/0", leds, dir, cycle_done, hl, hd);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 230; i++) begin
            tick();
            n_tests++;
            if ({leds, dir, rule_active, cycle_done} !== {e_leds, e_dir, e_rule, e_done}) begin
                n_fail++;
                $display("FAIL en_resume got %h/%b/%b/%b exp %h/%b/%b/%b", leds, dir, rule_active, cycle_done, e_leds, e_dir, e_rule, e_done);
            end
            en = ($urandom_range(0, 3) != 0);
        end
        en = 1'b1;
    endtask

    task automatic test_mode_switch();
        logic [N-1:0] tgt;
        tgt = pat(0, 11);
        mode = 2'b00; tick_div = '0;
        tick();
        mode = 2'b01;
        tick();
        for (int i = 0; i < 100 && leds !== tgt; i++) tick();
        n_tests++;
        if (leds !== tgt) begin n_fail++; $display("FAIL switch_reach got %h exp %h", leds, tgt); end
        mode = 2'b10;
        tick();
        n_tests++;
        if ({leds, dir, rule_active} !== {{N{1'b0}}, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL switch_reinit got %h/%b/%b exp 0/0/1", leds, dir, rule_active);
        end
        tick();
        n_tests++;
        if ({leds, dir, rule_active, cycle_done} !== {e_leds, e_dir, e_rule, e_done}) begin
            n_fail++;
            $display("FAIL switch_first_step got %h/%b/%b/%b exp %h/%b/%b/%b", leds, dir, rule_active, cycle_done, e_leds, e_dir, e_rule, e_done);
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] tgt;
        tgt = pat(1, 9);
        mode = 2'b11; tick_div = '0;
        tick();
        for (int i = 0; i < 400 && !(rule_active === 1'b1 && leds === tgt && dir === 1'b0); i++) tick();
        n_tests++;
        if (!(rule_active === 1'b1 && leds === tgt)) begin n_fail++; $display("FAIL rstmid_reach got %h/%b exp %h/1", leds, rule_active, tgt); end
        rst = 1'b1;
        tick();
        n_tests++;
        if ({leds, dir, rule_active, cycle_done} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_zero got %h/%b/%b/%b exp 0/0/0/0", leds, dir, rule_active, cycle_done);
        end
        rst = 1'b0;
        for (int i = 0; i < 110; i++) begin
            tick();
            n_tests++;
            if ({leds, dir, rule_active, cycle_done} !== {e_leds, e_dir, e_rule, e_done}) begin
                n_fail++;
                $display("FAIL rstmid_restart got %h/%b/%b/%b exp %h/%b/%b/%b", leds, dir, rule_active, cycle_done, e_leds, e_dir, e_rule, e_done);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) tick_div = PSW'($urandom_range(0, 3));
            en = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
            n_tests++;
            if ({leds, dir, rule_active, cycle_done} !== {e_leds, e_dir, e_rule, e_done}) begin
                n_fail++;
                $display("FAIL random_model got %h/%b/%b/%b exp %h/%b/%b/%b", leds, dir, rule_active, cycle_done, e_leds, e_dir, e_rule, e_done);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_converge();
        test_auto();
        test_prescale_en();
        test_mode_switch();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
